// File: rtl/if_fetch_pkg.sv
// Shared constants and the FIFO entry layout for the instruction-fetch stage.
// IF_ADEL_EN adds an address-error flag to every buffered entry.
package if_fetch_pkg;

    localparam int          INST_ADDR_BUS      = 32;
    localparam int          INST_BUS           = 32;
    localparam logic [31:0] ZERO_WORD          = 32'h0000_0000;
    localparam logic        ENABLE             = 1'b1;
    localparam logic        DISABLE            = 1'b0;
    localparam int          IF_FIFO_DEPTH_LOG2 = 1;

    typedef struct packed {
        logic [INST_ADDR_BUS-1:0] pc;
        logic [INST_BUS-1:0]      inst;
`ifdef IF_ADEL_EN
        logic                     adel;
`endif
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Misaligned targets are kept when the address-error flag can report them;
    // otherwise the target is forced onto a word boundary.
    function automatic logic [INST_ADDR_BUS-1:0] redirect_target(
        input logic [INST_ADDR_BUS-1:0] addr
    );
`ifdef IF_ADEL_EN
        return addr;
`else
        return addr & ~32'h0000_0003;
`endif
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with a clear input; push and pop may coincide at any
// occupancy, including full. The head reads as zero while empty.
module if_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; validity is defined solely by
    // count, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the ROM, buffers fetched
// {pc, inst} pairs toward ID. Optional IF_ADEL_EN flags misaligned fetches.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 1 << IF_FIFO_DEPTH_LOG2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] if_pc_o,
`ifdef IF_ADEL_EN
    output logic        if_excp_adel_o,
`endif
    output logic [31:0] if_inst_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               ce_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_next;
    logic               redirect;
    logic               pop;
    logic               fetch;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_count_unused;
    logic [ENTRY_W-1:0] fifo_rdata;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;

    assign redirect   = flush_i | branch_flag_i;
    assign pop        = if_valid_o & id_ready_i;
    assign fetch      = ce_q & (~fifo_full | pop);
    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q;

    // NOTE: every combinational output gets a default first so no path
    // through the block can leave a variable unassigned and infer a latch.
    always_comb begin
        pc_next = pc_q;
        if (flush_i)            pc_next = redirect_target(new_pc_i);
        else if (branch_flag_i) pc_next = redirect_target(branch_target_i);
        else if (fetch)         pc_next = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q <= DISABLE;
            pc_q <= RESET_PC;
        end else begin
            ce_q <= ENABLE;
            pc_q <= pc_next;
        end
    end

    // A misaligned fetch still occupies a slot but carries a nop.
    always_comb begin
        push_entry      = '0;
        push_entry.pc   = pc_q;
        push_entry.inst = rom_inst_i;
`ifdef IF_ADEL_EN
        push_entry.adel = (pc_q[1:0] != 2'b00);
        if (push_entry.adel) push_entry.inst = ZERO_WORD;
`endif
    end

    if_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .push  (fetch & ~redirect),
        .pop   (pop & ~redirect),
        .wdata (push_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_count_unused = ^fifo_count;

    assign head_entry = fetch_entry_t'(fifo_rdata);
    assign if_valid_o = ~fifo_empty;
    assign if_pc_o    = head_entry.pc;
    assign if_inst_o  = head_entry.inst;
`ifdef IF_ADEL_EN
    assign if_excp_adel_o = head_entry.adel;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, back-pressure, branch/flush
// redirects, misaligned flush target and an asynchronous mid-stream reset.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
`ifdef IF_ADEL_EN
    logic        if_excp_adel_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ROM word i holds 0x1000_0000 + i.
    assign rom_inst_i = 32'h1000_0000 + {2'b00, rom_addr_o[31:2]};

    if_fetch #(
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .if_valid_o      (if_valid_o),
        .id_ready_i      (id_ready_i),
        .if_pc_o         (if_pc_o),
`ifdef IF_ADEL_EN
        .if_excp_adel_o  (if_excp_adel_o),
`endif
        .if_inst_o       (if_inst_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, ".valid"}, {31'd0, if_valid_o}, 32'd1);
        check({tag, ".pc"}, if_pc_o, pc);
        check({tag, ".inst"}, if_inst_o, inst);
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, {31'd0, if_valid_o}, 32'd0);
        check({tag, ".pc"}, if_pc_o, 32'd0);
        check({tag, ".inst"}, if_inst_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'd0;
        flush_i         = 1'b0;
        new_pc_i        = 32'd0;
        id_ready_i      = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_empty("reset");
        check("reset.ce", {31'd0, rom_ce_o}, 32'd0);
        check("reset.addr", rom_addr_o, 32'h0);

        // Streaming: ce rises at cycle 1, valid from cycle 2 with no gaps
        rst_n = 1'b1;
        step();
        check("c1.ce", {31'd0, rom_ce_o}, 32'd1);
        check("c1.valid", {31'd0, if_valid_o}, 32'd0);
        step(); check_head("c2", 32'h00, 32'h1000_0000);
        step(); check_head("c3", 32'h04, 32'h1000_0001);
        step(); check_head("c4", 32'h08, 32'h1000_0002);
        step(); check_head("c5", 32'h0C, 32'h1000_0003);

        // Fresh start for the back-pressure scenario
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step(); check_head("bp.first", 32'h00, 32'h1000_0000);
        step(); check_head("bp.second", 32'h04, 32'h1000_0001);

        // Stall five cycles: FIFO fills to two, address parks at 0x0C
        id_ready_i = 1'b0;
        step(); check_head("stall1", 32'h04, 32'h1000_0001);
        check("stall1.addr", rom_addr_o, 32'h0C);
        for (int i = 0; i < 4; i++) step();
        check_head("stall5", 32'h04, 32'h1000_0001);
        check("stall5.addr", rom_addr_o, 32'h0C);

        // Release: 0x04 accepted, then 0x08, 0x0C with no drop or repeat
        id_ready_i = 1'b1;
        step(); check_head("rel1", 32'h08, 32'h1000_0002);
        check("rel1.addr", rom_addr_o, 32'h10);
        step(); check_head("rel2", 32'h0C, 32'h1000_0003);

        // FIFO full (0x0C, 0x10); branch to 0x100
        id_ready_i      = 1'b0;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h100;
        step();
        branch_flag_i = 1'b0;
        check_empty("br.next");
        check("br.addr", rom_addr_o, 32'h100);
        step(); check_head("br.first", 32'h100, 32'h1000_0040);
        step(); check_head("br.hold", 32'h100, 32'h1000_0040);

        // Flush and branch together: flush wins
        flush_i         = 1'b1;
        new_pc_i        = 32'h180;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h200;
        step();
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        id_ready_i    = 1'b1;
        check_empty("fl.next");
        check("fl.addr", rom_addr_o, 32'h180);
        step(); check_head("fl.h0", 32'h180, 32'h1000_0060);
        step(); check_head("fl.h1", 32'h184, 32'h1000_0061);
        step(); check_head("fl.h2", 32'h188, 32'h1000_0062);

        // Misaligned flush target
        flush_i  = 1'b1;
        new_pc_i = 32'h182;
        step();
        flush_i = 1'b0;
        check_empty("mis.next");
        step();
`ifdef IF_ADEL_EN
        check_head("mis.head", 32'h182, 32'h0000_0000);
        check("mis.adel", {31'd0, if_excp_adel_o}, 32'd1);
`else
        check_head("mis.head", 32'h180, 32'h1000_0060);
`endif

        // Fill the FIFO, then pulse reset mid-stream
        id_ready_i = 1'b0;
        step();
        step();
`ifdef IF_ADEL_EN
        check("full.addr", rom_addr_o, 32'h18A);
`else
        check("full.addr", rom_addr_o, 32'h188);
`endif
        rst_n = 1'b0;
        #1;
        check_empty("arst");
        check("arst.ce", {31'd0, rom_ce_o}, 32'd0);
        check("arst.addr", rom_addr_o, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        id_ready_i = 1'b1;
        step();
        check("rs1.ce", {31'd0, rom_ce_o}, 32'd1);
        check("rs1.valid", {31'd0, if_valid_o}, 32'd0);
        step(); check_head("rs2", 32'h00, 32'h1000_0000);
        step(); check_head("rs3", 32'h04, 32'h1000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch initiator for the OpenMIPS pipeline. It owns the PC, drives chip-enable and address to the combinational instruction ROM, and captures the returned word in the same cycle.
- Fetched {pc, inst} pairs are buffered in a small FIFO and handed to the ID stage with a valid/ready handshake.
- Branch and exception redirects flush the FIFO and retarget the PC.

Parameters:
- FIFO_DEPTH, 2, number of buffered {pc, inst} entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- rom_ce_o  out  1  ROM chip enable.
- rom_addr_o  out  32  byte address to ROM.
- rom_inst_i  in  32  ROM data, combinational from rom_addr_o.
- branch_flag_i  in  1  branch taken, single-cycle pulse from ID.
- branch_target_i  in  32  branch destination.
- flush_i  in  1  exception/eret flush from ctrl.
- new_pc_i  in  32  handler/return address, valid with flush_i.
- if_valid_o  out  1  FIFO head valid toward ID.
- id_ready_i  in  1  ID accepts head this cycle.
- if_pc_o  out  32  head PC.
- if_inst_o  out  32  head instruction.

Behaviour:
- Reset values: pc_q=RESET_PC, rom_ce_o=0, FIFO empty, if_valid_o=0, if_pc_o=0, if_inst_o=0.
- Output rule: if_pc_o and if_inst_o are 0 (ZeroWord) whenever the FIFO is empty.
- rom_addr_o = pc_q continuously.
- rom_ce_o is registered. It rises on the first clk edge after rst_n deasserts, so the first fetch occurs in the 2nd cycle out of reset. It stays 1 until the next reset.
- Fetch condition: fetch = rom_ce_o & (!full | pop), where pop = if_valid_o & id_ready_i.
- On fetch: push {pc_q, rom_inst_i} and set pc_q <= pc_q+4, wrapping at 32 bits. Sequential fetch latency is therefore 1 cycle from address to if_valid_o.
- When not fetching, pc_q holds; the ROM address is reissued each cycle until accepted.
- Push and pop in the same cycle are legal at any occupancy, including full. Occupancy is then unchanged.
- Redirect priority: flush_i > branch_flag_i > sequential.
  - flush_i=1: FIFO cleared, the current fetch is not pushed, pop is ignored, pc_q <= new_pc_i.
  - branch_flag_i=1 (no flush): FIFO cleared, current fetch not pushed, pop ignored, pc_q <= branch_target_i.
  - In both cases if_valid_o=0 in the following cycle. The first redirected instruction appears 2 cycles after the redirect pulse: fetched in cycle+1, valid in cycle+2.
- A redirect asserted while rom_ce_o=0 still updates pc_q.
- FIFO: binary read/write pointers of log2(FIFO_DEPTH) bits plus an occupancy count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight entries are lost; no output glitch is held past reset.

Optional Feature:
- Macro: IF_ADEL_EN.
- With the macro defined:
  - Each FIFO entry carries an extra bit adel = (pc[1:0]!=2'b00).
  - Extra output if_excp_adel_o (1 bit) reflects the head entry's bit; it is 0 when the FIFO is empty.
  - While pc_q is misaligned, rom_ce_o stays 1, but the pushed inst is forced to 0 (nop). pc_q still advances by 4, so the bad alignment persists until flush_i.
- Without the macro: no port. Redirect targets are taken with bits [1:0] forced to 2'b00.

Decomposition:
- Shared constants go in defines.v: ZeroWord, InstAddrBus, InstBus, Enable/Disable.
- New constant there: IfFifoDepthLog2.
- One natural sub-module: if_fifo, a parameterised synchronous FIFO with flush (clear) input, push/pop, full/empty/count. if_fetch holds the PC, ce register and redirect logic only.

Test Plan:
- Reset release, ROM word i = 32'h1000_0000+i, id_ready_i=1 -> rom_ce_o rises at cycle 1; if_valid_o from cycle 2. if_pc_o = 0,4,8,… and if_inst_o = 10000000, 10000001, … every cycle with no gaps.
- id_ready_i=0 for 5 cycles after the first valid -> FIFO fills to 2. rom_addr_o holds at 0x0C; if_pc_o holds at 0x04. On release the outputs resume 0x04, 0x08, 0x0C with no drops or duplicates.
- FIFO full, branch_flag_i=1 with target 0x100 -> next cycle if_valid_o=0. The following cycle if_pc_o=0x100 and if_inst_o=word 64.
- flush_i=1 (new_pc_i=0x180) and branch_flag_i=1 (target 0x200) in the same cycle -> pc_q=0x180; no 0x200 fetch ever appears at if_pc_o.
- IF_ADEL_EN defined, flush_i with new_pc_i=0x182 -> head if_pc_o=0x182, if_inst_o=0, if_excp_adel_o=1. Without the macro -> if_pc_o=0x180.
- rst_n pulsed low for 1 cycle mid-stream while the FIFO is full -> if_valid_o=0 and rom_ce_o=0 immediately. The fetch sequence restarts at RESET_PC.
